// File: rtl/lcd_timing_pkg.sv
// Shared types and default 480x272 timing for the LCD timing generator.
package lcd_timing_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, PREFILL = 2'd1, RUN = 2'd2} state_e;

  localparam int LCD_H_ACTIVE = 480;
  localparam int LCD_H_SYNC   = 41;
  localparam int LCD_H_BP     = 2;
  localparam int LCD_H_FP     = 2;
  localparam int LCD_V_ACTIVE = 272;
  localparam int LCD_V_SYNC   = 10;
  localparam int LCD_V_BP     = 2;
  localparam int LCD_V_FP     = 2;
  localparam int LCD_H_TOTAL  = LCD_H_SYNC + LCD_H_BP + LCD_H_ACTIVE + LCD_H_FP;
  localparam int LCD_V_TOTAL  = LCD_V_SYNC + LCD_V_BP + LCD_V_ACTIVE + LCD_V_FP;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_color_bar.sv
// Eight vertical colour bars selected by column; one register stage.
module lcd_color_bar
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = LCD_H_ACTIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pix_x_i,
  output logic [15:0] rgb_o
);

  localparam logic [9:0] BAR_W = 10'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);

  logic [9:0]  idx;
  logic [2:0]  sel;
  logic [15:0] rgb_q;

  always_comb begin
    idx = pix_x_i / BAR_W;
    sel = (idx > 10'd7) ? 3'd7 : idx[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= bar_color(sel);
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/lcd_timing_gen.sv
// HS/VS/DE timing, pixel coordinates and look-ahead FIFO reads for the RGB LCD.
// Optional colour-bar source and test_mode port behind LCD_TEST_PATTERN_EN.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = LCD_H_ACTIVE,
  parameter int H_SYNC   = LCD_H_SYNC,
  parameter int H_BP     = LCD_H_BP,
  parameter int H_FP     = LCD_H_FP,
  parameter int V_ACTIVE = LCD_V_ACTIVE,
  parameter int V_SYNC   = LCD_V_SYNC,
  parameter int V_BP     = LCD_V_BP,
  parameter int V_FP     = LCD_V_FP,
  parameter int DATA_W   = 16,
  parameter logic [DATA_W-1:0] UNDERFLOW_COLOR = DATA_W'(16'hF800)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              underflow_clr,
`ifdef LCD_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic [DATA_W-1:0] lcd_rgb,
  output logic [9:0]        pix_x,
  output logic [8:0]        pix_y,
  output logic              frame_start,
  output logic              underflow_flag
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_E = 10'(H_SYNC);
  localparam logic [9:0] H_DE_BEG = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_DE_END = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] X_MAX    = 10'(H_ACTIVE - 1);
  localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_SYNC_E = 9'(V_SYNC);
  localparam logic [8:0] V_DE_BEG = 9'(V_SYNC + V_BP);
  localparam logic [8:0] V_DE_END = 9'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [8:0] Y_MAX    = 9'(V_ACTIVE - 1);

  state_e      state_q, state_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [8:0]  v_cnt_q, v_cnt_d;

  logic        run, hs_pre, vs_pre, de_pre, rd, udf, tp;
  logic [9:0]  x_raw, x_d;
  logic [8:0]  y_raw, y_d;

  logic        hs_q, vs_q, de_q, rd_q, udf_q, fs_q, flag_q;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic [DATA_W-1:0] rgb;

`ifdef LCD_TEST_PATTERN_EN
  assign tp = test_mode;
`else
  assign tp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (en) state_d = PREFILL;
      end
      PREFILL: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (!en)             state_d = IDLE;
        else if (!fifo_empty) state_d = RUN;
      end
      RUN: begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == V_LAST) begin
            // Stop is only honoured at a frame boundary.
            v_cnt_d = '0;
            if (!en) state_d = IDLE;
          end else begin
            v_cnt_d = v_cnt_q + 9'd1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 10'd1;
        end
      end
      default: begin
        state_d = IDLE;
        h_cnt_d = '0;
        v_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    run    = (state_q == RUN);
    hs_pre = run && (h_cnt_q < H_SYNC_E);
    vs_pre = run && (v_cnt_q < V_SYNC_E);
    de_pre = run && (h_cnt_q >= H_DE_BEG) && (h_cnt_q < H_DE_END)
                 && (v_cnt_q >= V_DE_BEG) && (v_cnt_q < V_DE_END);
    rd     = de_pre && !fifo_empty && !tp;
    udf    = de_pre &&  fifo_empty && !tp;
    x_raw  = h_cnt_q - H_DE_BEG;
    y_raw  = v_cnt_q - V_DE_BEG;
    x_d    = '0;
    y_d    = '0;
    if (de_pre) begin
      x_d = (x_raw > X_MAX) ? X_MAX : x_raw;
      y_d = (y_raw > Y_MAX) ? Y_MAX : y_raw;
    end
  end

  assign fifo_rd_en = rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      rd_q    <= 1'b0;
      udf_q   <= 1'b0;
      fs_q    <= 1'b0;
      flag_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs_q    <= ~hs_pre;
      vs_q    <= ~vs_pre;
      de_q    <= de_pre;
      rd_q    <= rd;
      udf_q   <= udf;
      fs_q    <= run && (h_cnt_q == '0) && (v_cnt_q == '0);
      flag_q  <= udf | (flag_q & ~underflow_clr);
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  logic        tp_q;
  logic [15:0] bar_rgb;

  // Fed with the pre-cycle column so the registered bar lines up with lcd_de.
  lcd_color_bar #(.H_ACTIVE(H_ACTIVE)) u_bar (
    .clk     (clk),
    .rst     (rst),
    .pix_x_i (x_d),
    .rgb_o   (bar_rgb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tp_q <= 1'b0;
    else     tp_q <= tp;
  end
`endif

  // FIFO data arrives the cycle after the read strobe, same cycle as lcd_de.
  always_comb begin
    rgb = '0;
    if (rd_q)       rgb = fifo_rdata;
    else if (udf_q) rgb = UNDERFLOW_COLOR;
`ifdef LCD_TEST_PATTERN_EN
    if (tp_q) rgb = de_q ? DATA_W'(bar_rgb) : '0;
`endif
  end

  assign lcd_hs         = hs_q;
  assign lcd_vs         = vs_q;
  assign lcd_de         = de_q;
  assign lcd_rgb        = rgb;
  assign pix_x          = x_q;
  assign pix_y          = y_q;
  assign frame_start    = fs_q;
  assign underflow_flag = flag_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Randomized bench for lcd_timing_gen against a frame-position reference model,
// using a reduced timing so several whole frames fit in a short run.
module tb_lcd_timing_gen;

  localparam int HS = 5, HBP = 2, HA = 16, HFP = 3;
  localparam int VS = 2, VBP = 2, VA = 6,  VFP = 2;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int FT = HT * VT;
  localparam logic [15:0] UC = 16'hF800;

  logic        clk = 1'b0;
  logic        rst, en, fifo_empty, underflow_clr;
  logic        fifo_rd_en, lcd_hs, lcd_vs, lcd_de, frame_start, underflow_flag;
  logic [15:0] fifo_rdata = 16'h0000;
  logic [15:0] lcd_rgb;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HBP), .H_FP(HFP),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VBP), .V_FP(VFP),
    .DATA_W(16), .UNDERFLOW_COLOR(UC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .fifo_empty     (fifo_empty),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_rdata     (fifo_rdata),
    .underflow_clr  (underflow_clr),
`ifdef LCD_TEST_PATTERN_EN
    .test_mode      (1'b0),
`endif
    .lcd_hs         (lcd_hs),
    .lcd_vs         (lcd_vs),
    .lcd_de         (lcd_de),
    .lcd_rgb        (lcd_rgb),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .frame_start    (frame_start),
    .underflow_flag (underflow_flag)
  );

  // FIFO stand-in: hands out an incrementing word per read, never flushed.
  logic [15:0] fifo_word = 16'h0100;
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= fifo_word;
      fifo_word  <= fifo_word + 16'd1;
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] pk(input logic hs, input logic vs, input logic de,
                                     input logic fs, input logic fl, input logic [8:0] y,
                                     input logic [9:0] x, input logic [15:0] rgb);
    return {hs, vs, de, fs, fl, y, x, rgb};
  endfunction

  // Reference model: ms 0=stopped 1=waiting for data 2=scanning, mt = clocks into frame.
  int          ms = 0, mt = 0;
  logic        m_flag = 1'b0;
  logic [15:0] m_word = 16'h0100;
  logic [39:0] exp_out = '0;

  bit stats_on = 0, s_arm = 0;
  int s_cyc, s_hs, s_vs, s_de, s_rd;

  task automatic cyc(input logic r, input logic e, input logic emp, input logic clr);
    int h, v;
    logic hsp, vsp, dep, rdp;
    logic [15:0] rgbn;
    @(negedge clk);
    rst = r; en = e; fifo_empty = emp; underflow_clr = clr;
    #1;
    if (r) begin
      ms = 0; mt = 0; m_flag = 1'b0;
      exp_out = pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 10'd0, 16'd0);
    end
    chk("outs", 64'({lcd_hs, lcd_vs, lcd_de, frame_start, underflow_flag, pix_y, pix_x, lcd_rgb}),
        64'(exp_out));
    h   = mt % HT;
    v   = mt / HT;
    hsp = (ms == 2) && (h < HS);
    vsp = (ms == 2) && (v < VS);
    dep = (ms == 2) && (h >= HS + HBP) && (h < HS + HBP + HA) && (v >= VS + VBP) && (v < VS + VBP + VA);
    rdp = dep && !emp;
    chk("rd_en", 64'(fifo_rd_en), 64'(rdp));
    if (stats_on) begin
      if (frame_start) begin
        if (s_arm) begin
          chk("fs_gap", 64'(s_cyc), 64'(FT));
          chk("hs_low", 64'(s_hs), 64'(HS * VT));
          chk("vs_low", 64'(s_vs), 64'(VS * HT));
          chk("de_cnt", 64'(s_de), 64'(HA * VA));
          chk("rd_cnt", 64'(s_rd), 64'(HA * VA));
        end
        s_arm = 1; s_cyc = 0; s_hs = 0; s_vs = 0; s_de = 0; s_rd = 0;
      end
      s_cyc++;
      s_hs += int'(!lcd_hs);
      s_vs += int'(!lcd_vs);
      s_de += int'(lcd_de);
      s_rd += int'(fifo_rd_en);
    end
    if (!r) begin
      rgbn = rdp ? m_word : (dep ? UC : 16'd0);
      if (rdp) m_word++;
      m_flag  = (dep && emp) || (m_flag && !clr);
      exp_out = pk(!hsp, !vsp, dep, (ms == 2) && (mt == 0), m_flag,
                   dep ? 9'(v - (VS + VBP)) : 9'd0, dep ? 10'(h - (HS + HBP)) : 10'd0, rgbn);
      case (ms)
        0: if (e) ms = 1;
        1: if (!e) ms = 0; else if (!emp) begin ms = 2; mt = 0; end
        default: begin
          if (mt == FT - 1) begin mt = 0; if (!e) ms = 0; end
          else mt++;
        end
      endcase
    end
  endtask

  initial begin
    int fs_cnt;
    rst = 1'b1; en = 1'b1; fifo_empty = 1'b0; underflow_clr = 1'b0;

    repeat (3) cyc(1, 1, 0, 0);

    // Steady streaming with whole-frame statistics.
    stats_on = 1; s_arm = 0;
    repeat (3 * FT + 5) cyc(0, 1, 0, 0);
    stats_on = 0;

    // Five-clock underflow mid-line inside the active area, then clear.
    for (int i = 0; i < 2 * FT && mt != (VS + VBP + 2) * HT + HS + HBP + 4; i++) cyc(0, 1, 0, 0);
    repeat (5) cyc(0, 1, 1, 0);
    repeat (30) cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    repeat (10) cyc(0, 1, 0, 0);

    // Random empties and clears while scanning.
    repeat (2 * FT) cyc(0, 1, $urandom_range(3) == 0, $urandom_range(15) == 0);

    // Drop en mid-frame: frame must complete, then stop.
    for (int i = 0; i < 2 * FT && mt != 5 * HT + 3; i++) cyc(0, 1, 0, 0);
    repeat (FT + 20) cyc(0, 0, 0, 0);

    // Restart with an empty FIFO: no frame until data shows up.
    fs_cnt = 0;
    repeat (40) begin
      cyc(0, 1, 1, 0);
      fs_cnt += int'(frame_start);
    end
    chk("prefill_fs", 64'(fs_cnt), 64'd0);
    repeat (FT) cyc(0, 1, 0, 0);

    // Everything random, including resets and en toggling.
    repeat (3000) cyc($urandom_range(199) == 0, $urandom_range(99) != 0,
                      $urandom_range(4) == 0, $urandom_range(20) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Display-timing stage for the 480x272 RGB LCD, clocked by the pixel clock from the on-chip PLL output.
- Generates HS/VS/DE and pixel coordinates, and issues read requests to the camera frame FIFO one cycle ahead of DE so FIFO data lines up with DE.
- On FIFO underflow it substitutes a fill colour and raises a sticky flag.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_SYNC, 41, HS pulse width in clocks
- H_BP, 2, horizontal back porch
- H_FP, 2, horizontal front porch
- V_ACTIVE, 272, visible lines per frame
- V_SYNC, 10, VS pulse width in lines
- V_BP, 2, vertical back porch
- V_FP, 2, vertical front porch
- DATA_W, 16, pixel width (RGB565)
- UNDERFLOW_COLOR, 16'hF800, pixel driven when the FIFO is empty during active video

Ports:
- clk  in  1  pixel clock (PLL clkout0 domain)
- rst  in  1  asynchronous reset, active-high
- en  in  1  run request
- fifo_empty  in  1  frame FIFO empty flag
- fifo_rd_en  out  1  FIFO read strobe; data is valid on the next cycle
- fifo_rdata  in  DATA_W  FIFO read data
- underflow_clr  in  1  clears underflow_flag
- lcd_hs  out  1  horizontal sync, active-low
- lcd_vs  out  1  vertical sync, active-low
- lcd_de  out  1  data enable, active-high
- lcd_rgb  out  DATA_W  pixel data
- pix_x  out  10  active column 0..H_ACTIVE-1; 0 outside active region
- pix_y  out  9  active row 0..V_ACTIVE-1; 0 outside active region
- frame_start  out  1  one-cycle pulse on the first clock of each frame
- underflow_flag  out  1  sticky flag: an underflow has occurred

Behaviour:
- Derived constants: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (525); V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (286).
- Reset values: lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_rgb=0, fifo_rd_en=0, pix_x=0, pix_y=0, frame_start=0, underflow_flag=0, state=IDLE, h_cnt=0, v_cnt=0.
- States:
  - IDLE: counters held at 0; outputs at reset values. Go to PREFILL when en=1.
  - PREFILL: wait for fifo_empty=0, then go to RUN with h_cnt=v_cnt=0. If en drops here, return to IDLE.
  - RUN: h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments on h_cnt wrap and wraps at V_TOTAL-1.
  - RUN exit: at the last clock of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1), go to IDLE if en=0, otherwise continue. Dropping en mid-frame therefore always completes the frame.
- Pre-timing in RUN, combinational on the counters:
  - hs_pre = (h_cnt < H_SYNC)
  - vs_pre = (v_cnt < V_SYNC)
  - de_pre = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE)
- fifo_rd_en = de_pre & ~fifo_empty, combinational, issued in the pre-cycle.
- Outputs are registered one cycle after pre-timing:
  - lcd_hs = ~hs_pre, lcd_vs = ~vs_pre, lcd_de = de_pre
  - pix_x / pix_y are the active offsets of the previous counter values
  - frame_start = 1 when the previous counters were (0,0)
- Pixel data:
  - If the previous cycle read the FIFO, lcd_rgb = fifo_rdata.
  - Else if the previous cycle had de_pre=1 (underflow), lcd_rgb = UNDERFLOW_COLOR and underflow_flag is set.
  - Else lcd_rgb = 0.
- Flag priority: underflow_clr and a new underflow in the same cycle leave the flag set (set wins).
- Reset asserted mid-frame: immediate return to reset values. The FIFO is not flushed; that is the writer's responsibility.
- Coordinate widths: pix_x is 10 bits and pix_y 9 bits; both saturate safely at their maximum.

Optional Feature:
- Macro: LCD_TEST_PATTERN_EN.
- Defined: adds input test_mode (1 bit). When test_mode=1, fifo_rd_en is forced to 0, lcd_rgb shows 8 vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black in RGB565) selected by pix_x, and underflow detection is suppressed.
- Not defined: no test_mode port; behaviour exactly as above.

Decomposition:
- Package lcd_timing_pkg holds:
  - state enum {IDLE, PREFILL, RUN}
  - default 480x272 timing constants, H_TOTAL and V_TOTAL
  - RGB565 bar colour constants
- One sub-module, lcd_color_bar (pix_x in, rgb out, registered), instantiated only under LCD_TEST_PATTERN_EN.

Test Plan:
- Reset check: assert rst with en=1 -> all outputs at reset values; state IDLE.
- Frame timing: en=1, FIFO never empty.
  - Consecutive frame_start pulses are exactly 150150 clocks apart.
  - lcd_hs low for 41 clocks of every 525.
  - lcd_vs low for 10 lines (5250 clocks).
  - lcd_de high for 130560 clocks per frame; fifo_rd_en high for 130560 clocks per frame.
- Data alignment: FIFO model returns an incrementing counter -> lcd_rgb at pix_x=0, pix_y=0 equals the first word read; every lcd_de cycle matches the next word; underflow_flag stays 0.
- Underflow: force fifo_empty=1 for 5 clocks mid-line in active region -> fifo_rd_en=0 for those cycles; lcd_rgb=16'hF800 for 5 DE cycles; underflow_flag=1 and held until underflow_clr, then 0.
- Stop / prefill: drop en at v_cnt=100 -> frame completes through v_cnt=285, then IDLE with lcd_de=0. Re-assert en with fifo_empty=1 -> stays in PREFILL with no frame_start until empty deasserts.
- Test pattern (macro defined): test_mode=1 -> fifo_rd_en never asserts; pix_x 0..59 gives 16'hFFFF and 420..479 gives 16'h0000.
